// File: rtl/mem_access_unit.sv
// mem_access_unit
// MEM-stage load/store unit. Turns one load or store from the EX/MEM register
// into a single data-cache transaction (word-aligned address, byte mask,
// lane-replicated write data). It holds the pipeline until the cache answers,
// then returns the sign/zero-extended load value for one cycle.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   req_valid              MEM-stage instruction valid
//   mem_read, mem_write    memory-op flags of the MEM-stage control word
//   funct3                 access size/signedness (lb/lh/lw/lbu/lhu, sb/sh/sw)
//   addr, store_data       effective address and rs2 value
//   dmem_*                 data-cache request/response port
//   stall                  hold all pipeline registers this cycle
//   done                   one-cycle pulse, access finished (or faulted)
//   load_data, fault       result and status, valid while done=1
//                          (fault: 00 ok, 01 misaligned/illegal, 10 timeout)
module mem_access_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic [1:0]  fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter only has to reach MAX_WAIT-1.
  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  state_t         state_r, state_nx;
  logic [31:0]    addr_r;
  logic [2:0]     f3_r;
  logic           rd_r, wr_r;
  logic [3:0]     mask_r;
  logic [31:0]    wdata_r;
  logic [CW-1:0]  cnt_r;
  logic [31:0]    load_r;
  logic [1:0]     fault_r;

  logic           accept_s;
  logic           illegal_s;
  logic           timeout_s;
  logic [3:0]     mask_s;
  logic [31:0]    wdata_s;

  // Select the addressed byte/half of the returned word and extend it.
  function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  extend_load = {{24{sh[7]}}, sh[7:0]};
      3'b001:  extend_load = {{16{sh[15]}}, sh[15:0]};
      3'b010:  extend_load = rdata;
      3'b100:  extend_load = {24'd0, sh[7:0]};
      3'b101:  extend_load = {16'd0, sh[15:0]};
      default: extend_load = 32'd0;
    endcase
  endfunction

  assign accept_s  = req_valid & (mem_read | mem_write);
  assign timeout_s = (MAX_WAIT != 0) && (cnt_r == LAST_WAIT);

  // Legality of the incoming request: op combination, funct3 and alignment.
  always_comb begin
    illegal_s = 1'b0;
    if (mem_read && mem_write) begin
      illegal_s = 1'b1;
    end else if (mem_read) begin
      case (funct3)
        3'b000, 3'b100: illegal_s = 1'b0;
        3'b001, 3'b101: illegal_s = addr[0];
        3'b010:         illegal_s = |addr[1:0];
        default:        illegal_s = 1'b1;
      endcase
    end else begin
      case (funct3)
        3'b000:  illegal_s = 1'b0;
        3'b001:  illegal_s = addr[0];
        3'b010:  illegal_s = |addr[1:0];
        default: illegal_s = 1'b1;
      endcase
    end
  end

  // Store byte enables and lane-replicated data; loads carry no mask.
  always_comb begin
    mask_s  = 4'b0000;
    wdata_s = 32'd0;
    if (mem_write && !mem_read) begin
      case (funct3[1:0])
        2'b00: begin
          mask_s  = 4'b0001 << addr[1:0];
          wdata_s = {4{store_data[7:0]}};
        end
        2'b01: begin
          mask_s  = 4'b0011 << addr[1:0];
          wdata_s = {2{store_data[15:0]}};
        end
        2'b10: begin
          mask_s  = 4'b1111;
          wdata_s = store_data;
        end
        default: begin
          mask_s  = 4'b0000;
          wdata_s = 32'd0;
        end
      endcase
    end else begin
      mask_s  = 4'b0000;
      wdata_s = 32'd0;
    end
  end

  // State register plus the request/response holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      addr_r  <= 32'd0;
      f3_r    <= 3'd0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      mask_r  <= 4'd0;
      wdata_r <= 32'd0;
      cnt_r   <= '0;
      load_r  <= 32'd0;
      fault_r <= 2'b00;
    end else begin
      state_r <= state_nx;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            addr_r  <= addr;
            f3_r    <= funct3;
            rd_r    <= mem_read;
            wr_r    <= mem_write;
            mask_r  <= mask_s;
            wdata_r <= wdata_s;
            cnt_r   <= '0;
            load_r  <= 32'd0;
            fault_r <= illegal_s ? 2'b01 : 2'b00;
          end
        end
        WAIT: begin
          cnt_r <= cnt_r + 1'b1;
          // A response in the timeout cycle still completes normally.
          if (dmem_resp) begin
            load_r  <= rd_r ? extend_load(f3_r, addr_r[1:0], dmem_rdata) : 32'd0;
            fault_r <= 2'b00;
          end else if (timeout_s) begin
            load_r  <= 32'd0;
            fault_r <= 2'b10;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next state and outputs; cache port is driven only while waiting.
  always_comb begin
    state_nx     = state_r;
    stall        = 1'b0;
    done         = 1'b0;
    load_data    = 32'd0;
    fault        = 2'b00;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_address = 32'd0;
    dmem_wmask   = 4'd0;
    dmem_wdata   = 32'd0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          stall    = 1'b1;
          state_nx = illegal_s ? RESP : WAIT;
        end else begin
          state_nx = IDLE;
        end
      end
      WAIT: begin
        stall        = 1'b1;
        dmem_read    = rd_r;
        dmem_write   = wr_r;
        dmem_address = {addr_r[31:2], 2'b00};
        dmem_wmask   = mask_r;
        dmem_wdata   = wdata_r;
        if (dmem_resp || timeout_s) begin
          state_nx = RESP;
        end else begin
          state_nx = WAIT;
        end
      end
      RESP: begin
        done      = 1'b1;
        load_data = load_r;
        fault     = fault_r;
        state_nx  = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
